// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and index legality for the register file
package regfile_pkg;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned ADDR_W_DEF   = 4;
  localparam int unsigned PC_IDX_DEF   = 15;
  localparam int unsigned PC_RESET_DEF = 1;
  function automatic logic is_writable(input int unsigned idx, input int unsigned pc_idx, input bit zero_r0);
    return idx != pc_idx && !(zero_r0 && idx == 0);
  endfunction
endpackage

// File: rtl/regfile_if.sv
// regfile_if: decode/writeback bus to the register file
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) ();
  logic              rd_en;
  logic [ADDR_W-1:0] rs_a;
  logic [ADDR_W-1:0] rs_b;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              pc_we;
  logic [DATA_W-1:0] pc_wdata;
  logic [DATA_W-1:0] pc_out;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic              busy_a;
  logic              busy_b;
  modport master (
    output rd_en, rs_a, rs_b, we, waddr, wdata, pc_we, pc_wdata, issue_valid, issue_rd,
    input  rdata_a, rdata_b, pc_out, busy_a, busy_b
  );
  modport slave (
    input  rd_en, rs_a, rs_b, we, waddr, wdata, pc_we, pc_wdata, issue_valid, issue_rd,
    output rdata_a, rdata_b, pc_out, busy_a, busy_b
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits with two hazard lookups
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned PC_IDX  = PC_IDX_DEF,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_rd_i,
  input  logic              wr_valid_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [ADDR_W-1:0] rs_a_i,
  input  logic [ADDR_W-1:0] rs_b_i,
  output logic              busy_a_o,
  output logic              busy_b_o
);
  localparam int unsigned NREGS = 2**ADDR_W;
  logic [NREGS-1:0] busy_q, busy_d;
  // issue is applied after clear so a same-cycle reissue keeps the bit set
  always_comb begin
    busy_d = busy_q;
    if (wr_valid_i) busy_d[waddr_i] = 1'b0;
    if (issue_valid_i && is_writable(32'(issue_rd_i), PC_IDX, ZERO_R0)) busy_d[issue_rd_i] = 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) busy_q <= '0;
    else busy_q <= busy_d;
  assign busy_a_o = busy_q[rs_a_i] && !(wr_valid_i && waddr_i == rs_a_i);
  assign busy_b_o = busy_q[rs_b_i] && !(wr_valid_i && waddr_i == rs_b_i);
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: bypassed register file with protected PC and pending-write scoreboard
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned PC_IDX   = PC_IDX_DEF,
  parameter int unsigned PC_RESET = PC_RESET_DEF,
  parameter bit          ZERO_R0  = 1'b0
) (
  input logic      clk,
  input logic      reset,
  regfile_if.slave bus
);
  localparam int unsigned       NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A  = ADDR_W'(PC_IDX);
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] rdata_a_q, rdata_b_q, byp_a, byp_b;
  logic              wr_valid;
  assign wr_valid = bus.we && is_writable(32'(bus.waddr), PC_IDX, ZERO_R0);
  // in-flight writes are forwarded so reads never see a stale value
  assign byp_a = (ZERO_R0 && bus.rs_a == '0) ? '0 :
                 (wr_valid && bus.waddr == bus.rs_a) ? bus.wdata :
                 (bus.pc_we && bus.rs_a == PC_A) ? bus.pc_wdata : regs_q[bus.rs_a];
  assign byp_b = (ZERO_R0 && bus.rs_b == '0) ? '0 :
                 (wr_valid && bus.waddr == bus.rs_b) ? bus.wdata :
                 (bus.pc_we && bus.rs_b == PC_A) ? bus.pc_wdata : regs_q[bus.rs_b];
  always_comb begin
    regs_d = regs_q;
    if (wr_valid) regs_d[bus.waddr] = bus.wdata;
    if (bus.pc_we) regs_d[PC_A] = bus.pc_wdata;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= (i == PC_IDX) ? DATA_W'(PC_RESET) : '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      regs_q    <= regs_d;
      rdata_a_q <= bus.rd_en ? byp_a : rdata_a_q;
      rdata_b_q <= bus.rd_en ? byp_b : rdata_b_q;
    end
  assign bus.rdata_a = rdata_a_q;
  assign bus.rdata_b = rdata_b_q;
  assign bus.pc_out  = regs_q[PC_A];
  regfile_scoreboard #(.ADDR_W(ADDR_W), .PC_IDX(PC_IDX), .ZERO_R0(ZERO_R0)) u_sb (
    .clk          (clk),
    .reset        (reset),
    .issue_valid_i(bus.issue_valid),
    .issue_rd_i   (bus.issue_rd),
    .wr_valid_i   (wr_valid),
    .waddr_i      (bus.waddr),
    .rs_a_i       (bus.rs_a),
    .rs_b_i       (bus.rs_b),
    .busy_a_o     (bus.busy_a),
    .busy_b_o     (bus.busy_b)
  );
endmodule
